// File: rtl/lo_sle_pkg.sv
// Shared definitions for the LO_SLE serial writer.
//   - default word length and phase length
//   - writer state encoding
//   - bit positions inside the status readback word
package lo_sle_pkg;

    localparam int DEFAULT_CLK_DIV = 4;   // user_clk cycles per serial half-bit
    localparam int DEFAULT_NBITS   = 24;  // synthesizer word length

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        SHIFT_HI = 3'd2,
        SHIFT_LO = 3'd3,
        LATCH    = 3'd4
    } lo_sle_state_e;

    // status_out = {overflow, pending, busy, 13'b0, xfer_count[15:0]}
    localparam int STAT_OVERFLOW_BIT = 31;
    localparam int STAT_PENDING_BIT  = 30;
    localparam int STAT_BUSY_BIT     = 29;
    localparam int STAT_COUNT_MSB    = 15;

endpackage

// File: rtl/lo_sle_tick.sv
// Phase timer for the serial writer.
// Counts CLK_DIV cycles and raises phase_end on the last cycle of every
// phase. The counter wraps on phase_end so back-to-back phases need no
// restart; restart holds it at zero (used while the writer is idle).
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   restart   : force the count back to zero
//   phase_end : one-cycle strobe on the final cycle of a phase
module lo_sle_tick
    import lo_sle_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_end
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign phase_end = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/lo_sle_serial_writer.sv
// LO synthesizer serial writer.
// Software flips reg_data[31] to request a transfer of reg_data[NBITS-1:0].
// The word is shifted MSB first on lo_sdata, qualified by lo_sclk rising
// edges, then latched with a 2*CLK_DIV-cycle lo_sle pulse.
//
// Request semantics: a request is any cycle where reg_data[31] differs from
// its value one cycle earlier. An idle writer accepts it immediately. A busy
// writer holds one request in 'pending' and starts it from IDLE the cycle
// after LATCH, sampling the payload at that moment. Any further request while
// one is pending is dropped and sets the sticky 'overflow' flag.
//
// Ports:
//   user_clk, user_rst_n : clock, synchronous active-low reset
//   reg_data[31:0]       : start toggle (bit 31) and payload (NBITS-1:0)
//   lo_sclk, lo_sdata    : serial clock and data to the synthesizer
//   lo_sle               : latch enable, active high
//   busy                 : transfer in progress
//   status_out[31:0]     : {overflow, pending, busy, 13'b0, xfer_count}
module lo_sle_serial_writer
    import lo_sle_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int NBITS   = DEFAULT_NBITS
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] reg_data,
    output logic        lo_sclk,
    output logic        lo_sdata,
    output logic        lo_sle,
    output logic        busy,
    output logic [31:0] status_out
);

    // Bit count reached once the final bit's high phase has completed.
    localparam logic [4:0] LAST_BIT = 5'(NBITS);

    lo_sle_state_e    state, state_nxt;
    logic             tog_prev;
    logic             start_req;
    logic [NBITS-1:0] shift_q;
    logic [4:0]       bit_cnt;
    logic             latch_half;
    logic             pending;
    logic             overflow;
    logic [15:0]      xfer_count;

    logic phase_end;
    logic tick_restart;
    logic load_shift;
    logic shift_en;
    logic latch_flip;
    logic xfer_done;

    // Payload bits above NBITS are deliberately ignored.
    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_data;

    assign start_req = reg_data[31] ^ tog_prev;

    lo_sle_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (user_clk),
        .rst_n     (user_rst_n),
        .restart   (tick_restart),
        .phase_end (phase_end)
    );

    // Next-state and control strobes.
    always_comb begin
        state_nxt    = state;
        tick_restart = 1'b0;
        load_shift   = 1'b0;
        shift_en     = 1'b0;
        latch_flip   = 1'b0;
        xfer_done    = 1'b0;
        case (state)
            IDLE: begin
                tick_restart = 1'b1;
                if (start_req || pending) begin
                    state_nxt  = SETUP;
                    load_shift = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    state_nxt = SHIFT_LO;
                    shift_en  = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_end) state_nxt = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_HI;
            end
            LATCH: begin
                // Two timer periods: the first flips latch_half, the second exits.
                if (phase_end) begin
                    if (latch_half) begin
                        state_nxt = IDLE;
                        xfer_done = 1'b1;
                    end else begin
                        latch_flip = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge user_clk) begin
        // The toggle history follows reg_data even in reset, so releasing
        // reset never looks like a request.
        tog_prev <= reg_data[31];
        if (!user_rst_n) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_cnt    <= '0;
            latch_half <= 1'b0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;

            if (load_shift) begin
                shift_q <= reg_data[NBITS-1:0];
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_q <= shift_q << 1;
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (xfer_done) begin
                latch_half <= 1'b0;
            end else if (latch_flip) begin
                latch_half <= 1'b1;
            end

            if (state == IDLE) begin
                // A held request is consumed here; a fresh request in the
                // same cycle re-arms it instead of being lost.
                if (pending) pending <= start_req;
            end else if (start_req) begin
                if (pending) overflow <= 1'b1;
                else         pending  <= 1'b1;
            end

            if (xfer_done) xfer_count <= xfer_count + 16'd1;
        end
    end

    // Outputs decode straight from registered state.
    always_comb begin
        lo_sclk  = (state == SHIFT_HI);
        lo_sle   = (state == LATCH);
        busy     = (state != IDLE);
        lo_sdata = 1'b0;
        if (state == SETUP || state == SHIFT_HI || state == SHIFT_LO) begin
            lo_sdata = shift_q[NBITS-1];
        end
    end

    always_comb begin
        status_out = '0;
        status_out[STAT_OVERFLOW_BIT]  = overflow;
        status_out[STAT_PENDING_BIT]   = pending;
        status_out[STAT_BUSY_BIT]      = busy;
        status_out[STAT_COUNT_MSB:0]   = xfer_count;
    end

endmodule

// File: tb/tb_lo_sle_serial_writer.sv
module tb_lo_sle_serial_writer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] reg_data;
  logic [31:0] reg_data_s;

  logic        sclk, sdata, sle, busy;
  logic [31:0] status;
  logic        sclk_s, sdata_s, sle_s, busy_s;
  logic [31:0] status_s;

  lo_sle_serial_writer dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .reg_data   (reg_data),
    .lo_sclk    (sclk),
    .lo_sdata   (sdata),
    .lo_sle     (sle),
    .busy       (busy),
    .status_out (status)
  );

  lo_sle_serial_writer #(.CLK_DIV(1), .NBITS(1)) dut_small (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .reg_data   (reg_data_s),
    .lo_sclk    (sclk_s),
    .lo_sdata   (sdata_s),
    .lo_sle     (sle_s),
    .busy       (busy_s),
    .status_out (status_s)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  // Running totals collected on every falling edge.
  int          rise_cnt = 0;
  int          sle_cnt  = 0;
  int          busy_cnt = 0;
  logic [31:0] cap_word = '0;
  logic        sclk_d   = 1'b0;

  int          rise_cnt_s = 0;
  int          sle_cnt_s  = 0;
  int          busy_cnt_s = 0;
  logic        cap_bit_s  = 1'b0;
  logic        sclk_d_s   = 1'b0;

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_d === 1'b0) begin
      rise_cnt = rise_cnt + 1;
      cap_word = {cap_word[30:0], sdata};
    end
    if (sle === 1'b1)  sle_cnt  = sle_cnt + 1;
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    sclk_d = sclk;

    if (sclk_s === 1'b1 && sclk_d_s === 1'b0) begin
      rise_cnt_s = rise_cnt_s + 1;
      cap_bit_s  = sdata_s;
    end
    if (sle_s === 1'b1)  sle_cnt_s  = sle_cnt_s + 1;
    if (busy_s === 1'b1) busy_cnt_s = busy_cnt_s + 1;
    sclk_d_s = sclk_s;
  end

  // ---------------- driver tasks ----------------
  // Act just after the falling edge, after the monitor has updated.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_count(input string name, input logic [15:0] target, input int budget);
    int n;
    n = 0;
    while (!(status[15:0] === target && busy === 1'b0) && n < budget) begin
      step();
      n = n + 1;
    end
    if (n >= budget) begin
      errors = errors + 1;
      checks = checks + 1;
      $display("FAIL %s_timeout: count 0x%04h expected 0x%04h", name, status[15:0], target);
    end
  endtask

  task automatic toggle(input logic [23:0] payload, input logic [6:0] junk);
    reg_data = {~reg_data[31], junk, payload};
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [23:0] payload;
    logic [6:0]  junk;
    logic [23:0] exp_bits;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int b0, s0, r0, n;
    logic [15:0] cnt;

    vecs[0] = '{payload: 24'h123456, junk: 7'h00, exp_bits: 24'b0001_0010_0011_0100_0101_0110, exp_count: 16'd1};
    vecs[1] = '{payload: 24'hFFFFFF, junk: 7'h7F, exp_bits: 24'b1111_1111_1111_1111_1111_1111, exp_count: 16'd2};
    vecs[2] = '{payload: 24'h000001, junk: 7'h55, exp_bits: 24'b0000_0000_0000_0000_0000_0001, exp_count: 16'd3};
    vecs[3] = '{payload: 24'hA5A5A5, junk: 7'h2A, exp_bits: 24'b1010_0101_1010_0101_1010_0101, exp_count: 16'd4};
    vecs[4] = '{payload: 24'h800000, junk: 7'h01, exp_bits: 24'b1000_0000_0000_0000_0000_0000, exp_count: 16'd5};

    // Reset with the toggle already high: release must not start anything.
    rst_n      = 1'b0;
    reg_data   = 32'h8012_3456;
    reg_data_s = 32'h0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("rst_busy",   {31'b0, busy}, 32'h0);
    check("rst_status", status, 32'h0);
    check("rst_pins",   {29'b0, sclk, sdata, sle}, 32'h0);
    check("rst_rises",  rise_cnt, 0);
    check("rst_sle",    sle_cnt, 0);

    // Single transfers from the table.
    for (int i = 0; i < 5; i++) begin
      b0 = busy_cnt; s0 = sle_cnt; r0 = rise_cnt;
      toggle(vecs[i].payload, vecs[i].junk);
      wait_count($sformatf("vec%0d", i), vecs[i].exp_count, 600);
      check($sformatf("vec%0d_bits", i),  {8'b0, cap_word[23:0]}, {8'b0, vecs[i].exp_bits});
      check($sformatf("vec%0d_rises", i), rise_cnt - r0, 24);
      check($sformatf("vec%0d_sle", i),   sle_cnt - s0, 8);
      check($sformatf("vec%0d_busy", i),  busy_cnt - b0, 204);
      check($sformatf("vec%0d_stat", i),  status, {16'h0, vecs[i].exp_count});
    end

    // Second request during a transfer runs back to back.
    b0 = busy_cnt; s0 = sle_cnt;
    toggle(24'h0F0F0F, 7'h0);
    repeat (50) step();
    check("b2b_busy_mid", {31'b0, busy}, 32'h1);
    toggle(24'h3C3C3C, 7'h0);
    step();
    check("b2b_pending", {30'b0, status[31:30]}, 32'h1);
    wait_count("b2b", 16'd7, 1000);
    check("b2b_bits",  {8'b0, cap_word[23:0]}, 32'h003C3C3C);
    check("b2b_busy",  busy_cnt - b0, 408);
    check("b2b_sle",   sle_cnt - s0, 16);
    check("b2b_stat",  status, 32'h0000_0007);

    // Three requests in one transfer: one dropped, overflow sticks.
    toggle(24'h111111, 7'h0);
    repeat (20) step();
    toggle(24'h222222, 7'h0);
    repeat (20) step();
    toggle(24'h333333, 7'h0);
    step();
    check("ovf_flag", {29'b0, status[31:29]}, 32'h7);
    wait_count("ovf", 16'd9, 1000);
    check("ovf_bits", {8'b0, cap_word[23:0]}, 32'h00333333);
    repeat (300) step();
    check("ovf_stat", status, 32'h8000_0009);

    // Reset in the middle of a transfer.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("abort_pre_stat", status, 32'h0);
    r0 = rise_cnt; s0 = sle_cnt;
    toggle(24'h654321, 7'h0);
    n = 0;
    while (rise_cnt - r0 < 10 && n < 400) begin
      step();
      n = n + 1;
    end
    check("abort_reached_10", rise_cnt - r0, 10);
    rst_n = 1'b0;
    step();
    check("abort_pins", {28'b0, sclk, sdata, sle, busy}, 32'h0);
    check("abort_stat", status, 32'h0);
    rst_n = 1'b1;
    repeat (300) step();
    check("abort_sle", sle_cnt - s0, 0);
    check("abort_post_stat", status, 32'h0);

    // Count wrap from 0xFFFF.
    force dut.xfer_count = 16'hFFFF;
    step();
    release dut.xfer_count;
    step();
    check("wrap_pre", status, 32'h0000_FFFF);
    toggle(24'hC0FFEE, 7'h0);
    wait_count("wrap", 16'h0000, 600);
    check("wrap_bits", {8'b0, cap_word[23:0]}, 32'h00C0FFEE);
    check("wrap_stat", status, 32'h0);

    // Smallest configuration: one bit, one cycle per phase.
    for (int k = 0; k < 2; k++) begin
      b0 = busy_cnt_s; s0 = sle_cnt_s; r0 = rise_cnt_s;
      reg_data_s = {~reg_data_s[31], 30'h0, (k == 0) ? 1'b1 : 1'b0};
      n = 0;
      cnt = 16'(k + 1);
      while (!(status_s[15:0] === cnt && busy_s === 1'b0) && n < 50) begin
        step();
        n = n + 1;
      end
      check($sformatf("small%0d_done", k), {31'b0, n < 50}, 32'h1);
      check($sformatf("small%0d_busy", k), busy_cnt_s - b0, 5);
      check($sformatf("small%0d_sle", k),  sle_cnt_s - s0, 2);
      check($sformatf("small%0d_rise", k), rise_cnt_s - r0, 1);
      check($sformatf("small%0d_bit", k),  {31'b0, cap_bit_s}, (k == 0) ? 32'h1 : 32'h0);
      check($sformatf("small%0d_stat", k), status_s, {16'h0, cnt});
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
